// File: rtl/apb_arb_master.sv
// APB requester shared by two clients: round-robin arbitration, a wait-state
// timeout, and registered one-cycle response pulses back to the winner.
module apb_arb_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              req_accept,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    PSELx,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t     state, next_state;
  logic       last_grant;
  logic       grant;
  logic       winner;
  logic [7:0] wait_cnt;
  logic       done;
  logic       timed_out;

  assign done      = (state == ACCESS) && PREADY;
  assign timed_out = (state == ACCESS) && !PREADY && (wait_cnt == 8'(TIMEOUT - 1));
  assign PSELx     = (state != IDLE);
  assign PENABLE   = (state == ACCESS);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= next_state;
  end

  // req_accept is gated by PRESETn so a held request cannot show through reset.
  always_comb begin
    next_state = state;
    req_accept = '0;
    winner     = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    case (state)
      IDLE: begin
        if (|req_valid) begin
          next_state         = SETUP;
          req_accept[winner] = PRESETn;
        end
      end
      SETUP:   next_state = ACCESS;
      ACCESS:  if (done || timed_out) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      last_grant <= 1'b1;
      grant      <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      wait_cnt   <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;

      if (state == IDLE && |req_valid) begin
        grant      <= winner;
        last_grant <= winner;
        PWRITE     <= req_write[winner];
        PADDR      <= winner ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
        PWDATA     <= winner ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
      end

      if (state == SETUP)                 wait_cnt <= '0;
      else if (state == ACCESS && !PREADY) wait_cnt <= wait_cnt + 8'd1;

      // Writes return zero read data; a timeout reports an error with no data.
      if (done) begin
        rsp_valid[grant] <= 1'b1;
        rsp_rdata        <= PWRITE ? '0 : PRDATA;
        rsp_err          <= PSLVERR;
      end else if (timed_out) begin
        rsp_valid[grant] <= 1'b1;
        rsp_err          <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_arb_master.sv
// Bench for apb_arb_master: directed scenarios with literal expectations, then
// random traffic checked every cycle against a transaction-level model.
module tb_apb_arb_master;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic          PCLK;
  logic          PRESETn;
  logic [1:0]    req_valid;
  logic [1:0]    req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]    req_accept;
  logic [1:0]    rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          PSELx;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  int vectors     = 0;
  int miscompares = 0;
  logic [1:0] last_acc;

  // Model state: one transfer in flight, described by its age and stall count.
  logic        m_busy, m_last, m_grantee, m_write;
  int          m_age, m_lows;
  logic [31:0] m_addr, m_wdata, m_rsp_d;
  logic [1:0]  m_rsp_v;
  logic        m_rsp_e;

  apb_arb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_accept(req_accept), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic newReq(input int i, input bit wr_only);
    req_valid[i]          = 1'b1;
    req_write[i]          = wr_only ? 1'b1 : 1'($urandom_range(0, 1));
    req_addr[i*AW +: AW]  = $urandom;
    req_wdata[i*DW +: DW] = $urandom;
  endtask

  task automatic presentReq(input int i, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    req_valid[i]          = 1'b1;
    req_write[i]          = wr;
    req_addr[i*AW +: AW]  = addr;
    req_wdata[i*DW +: DW] = wd;
  endtask

  task automatic finishCycle();
    @(negedge PCLK);
    last_acc = req_accept;
  endtask

  // Requesters drop a request once accepted, optionally re-presenting a new one.
  task automatic applyStimulus(input logic rst_n_v, input logic [1:0] refill, input bit wr_only,
                               input bit auto_start, input logic rdy, input logic [31:0] prd,
                               input logic slv);
    @(posedge PCLK);
    #1;
    PRESETn = rst_n_v;
    for (int i = 0; i < 2; i++) begin
      if (last_acc[i]) begin
        req_valid[i] = 1'b0;
        if (refill[i]) newReq(i, wr_only);
      end else if (!req_valid[i] && auto_start && ($urandom_range(0, 1) == 1)) begin
        newReq(i, wr_only);
      end
    end
    PREADY  = rdy;
    PRDATA  = prd;
    PSLVERR = slv;
    finishCycle();
  endtask

  task automatic resetDut();
    @(posedge PCLK);
    #1;
    PRESETn   = 1'b0;
    req_valid = '0;
    last_acc  = '0;
    @(negedge PCLK);
    checkOutput("rst_psel", 64'(PSELx), 64'd0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
  endtask

  initial begin : scoreboard
    logic [1:0]  exp_acc, nv;
    logic        win, ne;
    logic [31:0] nd;
    int          wi;
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        checkOutput("rst_ctrl", 64'({req_accept, rsp_valid, rsp_err, PSELx, PENABLE, PWRITE}), 64'd0);
        checkOutput("rst_paddr", 64'(PADDR), 64'd0);
        checkOutput("rst_pwdata", 64'(PWDATA), 64'd0);
        checkOutput("rst_rdata", 64'(rsp_rdata), 64'd0);
        m_busy = 1'b0; m_last = 1'b1; m_grantee = 1'b0; m_write = 1'b0;
        m_age = 0; m_lows = 0; m_addr = '0; m_wdata = '0;
        m_rsp_v = '0; m_rsp_d = '0; m_rsp_e = 1'b0;
      end else begin
        exp_acc = '0;
        win = (req_valid == 2'b11) ? ~m_last : req_valid[1];
        wi  = int'(win);
        if (!m_busy && req_valid != 2'b00) exp_acc[win] = 1'b1;
        checkOutput("req_accept", 64'(req_accept), 64'(exp_acc));
        checkOutput("psel", 64'(PSELx), 64'(m_busy));
        checkOutput("penable", 64'(PENABLE), 64'(m_busy && m_age >= 1));
        checkOutput("pwrite", 64'(PWRITE), 64'(m_write));
        checkOutput("paddr", 64'(PADDR), 64'(m_addr));
        checkOutput("pwdata", 64'(PWDATA), 64'(m_wdata));
        checkOutput("rsp_valid", 64'(rsp_valid), 64'(m_rsp_v));
        if (m_rsp_v != 2'b00) begin
          checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(m_rsp_d));
          checkOutput("rsp_err", 64'(rsp_err), 64'(m_rsp_e));
        end
        nv = '0; nd = '0; ne = 1'b0;
        if (m_busy) begin
          if (m_age >= 1) begin
            if (PREADY) begin
              nv[m_grantee] = 1'b1;
              nd = m_write ? 32'd0 : PRDATA;
              ne = PSLVERR;
              m_busy = 1'b0;
            end else begin
              m_lows++;
              if (m_lows >= TIMEOUT) begin
                nv[m_grantee] = 1'b1;
                ne = 1'b1;
                m_busy = 1'b0;
              end
            end
          end
          m_age++;
        end else if (req_valid != 2'b00) begin
          m_busy = 1'b1; m_age = 0; m_lows = 0;
          m_grantee = win; m_last = win;
          m_write = req_write[win];
          m_addr  = req_addr[wi*AW +: AW];
          m_wdata = req_wdata[wi*DW +: DW];
        end
        m_rsp_v = nv; m_rsp_d = nd; m_rsp_e = ne;
      end
    end
  end

  initial begin : stimulus
    logic [1:0]  grant_seq [4];
    logic [31:0] cur_wd;
    int k, pen, rspc, stall;
    logic bad;

    grant_seq[0] = 2'b01; grant_seq[1] = 2'b10; grant_seq[2] = 2'b01; grant_seq[3] = 2'b10;
    PRESETn = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0; last_acc = '0;

    // Single read, zero wait states.
    resetDut();
    presentReq(0, 1'b0, 32'h10, 32'h0);
    PREADY = 1'b1; PRDATA = 32'hA5A5A5A5; PSLVERR = 1'b0;
    finishCycle();
    checkOutput("t1_accept", 64'(req_accept), 64'h1);
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0);
    checkOutput("t1_setup", 64'({PSELx, PENABLE}), 64'h2);
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0);
    checkOutput("t1_access", 64'({PSELx, PENABLE}), 64'h3);
    checkOutput("t1_paddr", 64'(PADDR), 64'h10);
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0);
    checkOutput("t1_rsp_valid", 64'(rsp_valid), 64'h1);
    checkOutput("t1_rsp_rdata", 64'(rsp_rdata), 64'hA5A5A5A5);
    checkOutput("t1_rsp_err", 64'(rsp_err), 64'h0);

    // Both requesters writing continuously: grants must alternate.
    resetDut();
    presentReq(0, 1'b1, 32'h100, $urandom);
    presentReq(1, 1'b1, 32'h200, $urandom);
    PREADY = 1'b1; PSLVERR = 1'b0;
    finishCycle();
    k = 0; cur_wd = '0;
    for (int c = 0; c < 13; c++) begin
      if (c > 0) applyStimulus(1'b1, 2'b11, 1'b1, 1'b0, 1'b1, $urandom, 1'b0);
      if (req_accept != 2'b00) begin
        if (k < 4) checkOutput($sformatf("t2_grant%0d", k), 64'(req_accept), 64'(grant_seq[k]));
        cur_wd = req_accept[1] ? req_wdata[63:32] : req_wdata[31:0];
        k++;
      end
      if (PENABLE) checkOutput("t2_pwdata", 64'(PWDATA), 64'(cur_wd));
    end
    checkOutput("t2_ngrants", 64'(k), 64'd5);

    // Three wait states, then ready.
    resetDut();
    presentReq(0, 1'b0, 32'h20, 32'h0);
    PREADY = 1'b1;
    finishCycle();
    pen = 0; rspc = 0; bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, (c >= 2 && c <= 4) ? 1'b0 : 1'b1, $urandom, 1'b0);
      pen  += int'(PENABLE);
      rspc += int'(rsp_valid != 2'b00);
      if (PSELx && PADDR != 32'h20) bad = 1'b1;
    end
    checkOutput("t3_penable_cycles", 64'(pen), 64'd4);
    checkOutput("t3_rsp_pulses", 64'(rspc), 64'd1);
    checkOutput("t3_addr_stable", 64'(bad), 64'd0);

    // Completer never ready: timeout after TIMEOUT access cycles.
    resetDut();
    presentReq(1, 1'b1, 32'h30, 32'hDEADBEEF);
    PREADY = 1'b0;
    finishCycle();
    pen = 0; rspc = 0;
    for (int c = 0; c < 25; c++) begin
      if (c > 0) applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, $urandom, 1'b0);
      pen += int'(PENABLE);
      if (rsp_valid != 2'b00) begin
        rspc++;
        checkOutput("t4_rsp_valid", 64'(rsp_valid), 64'h2);
        checkOutput("t4_rsp_err", 64'(rsp_err), 64'h1);
        checkOutput("t4_rsp_rdata", 64'(rsp_rdata), 64'h0);
      end
    end
    checkOutput("t4_penable_cycles", 64'(pen), 64'd16);
    checkOutput("t4_rsp_pulses", 64'(rspc), 64'd1);

    // Completer error response.
    @(posedge PCLK);
    #1;
    presentReq(0, 1'b0, 32'h400, 32'h0);
    PREADY = 1'b1; PSLVERR = 1'b1;
    finishCycle();
    rspc = 0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, $urandom, 1'b1);
      if (rsp_valid != 2'b00) begin
        rspc++;
        checkOutput("t6_rsp_valid", 64'(rsp_valid), 64'h1);
        checkOutput("t6_rsp_err", 64'(rsp_err), 64'h1);
      end
    end
    checkOutput("t6_rsp_pulses", 64'(rspc), 64'd1);

    // Reset in the middle of ACCESS, request still held afterwards.
    @(posedge PCLK);
    #1;
    presentReq(0, 1'b0, 32'h50, 32'h0);
    PREADY = 1'b0; PSLVERR = 1'b0;
    finishCycle();
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, $urandom, 1'b0);
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, $urandom, 1'b0);
    checkOutput("t5_in_access", 64'({PSELx, PENABLE}), 64'h3);
    @(posedge PCLK);
    #1;
    PRESETn = 1'b0;
    #1;
    checkOutput("t5_psel_async", 64'(PSELx), 64'd0);
    checkOutput("t5_penable_async", 64'(PENABLE), 64'd0);
    finishCycle();
    checkOutput("t5_no_rsp0", 64'(rsp_valid), 64'd0);
    @(posedge PCLK);
    #1;
    finishCycle();
    checkOutput("t5_no_rsp1", 64'(rsp_valid), 64'd0);
    @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    finishCycle();
    checkOutput("t5_reaccept", 64'(req_accept), 64'h1);
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, $urandom, 1'b0);
    checkOutput("t5_setup", 64'({PSELx, PENABLE}), 64'h2);
    checkOutput("t5_no_rsp2", 64'(rsp_valid), 64'd0);

    // Random traffic with occasional long stalls and stray resets.
    stall = 0;
    for (int c = 0; c < 3000; c++) begin
      logic rdy, rn;
      if (stall > 0) begin
        rdy = 1'b0;
        stall--;
      end else if ($urandom_range(0, 99) == 0) begin
        stall = int'($urandom_range(10, 24));
        rdy = 1'b0;
      end else begin
        rdy = ($urandom_range(0, 2) != 0);
      end
      rn = ($urandom_range(0, 399) != 0);
      applyStimulus(rn, 2'($urandom_range(0, 3)), 1'b0, 1'b1, rdy, $urandom, ($urandom_range(0, 7) == 0));
    end

    @(posedge PCLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
